mdio_arbiter: RTL and testbench

- Shares one MDIO management controller between N_REQ independent requesters, e.g. the link-config FSM, the status poller and the debug port.
- Arbitrates round-robin, latches the winner's 32-bit Clause-22 frame and issues a single start pulse to the controller.
- Waits for the controller's completion, returns read data and a per-requester done, and enforces a timeout and an inter-frame idle gap.
- Sits between the requester logic and the MDIO controller, in the CLK domain.

---
 rtl/mdio_arbiter_pkg.sv | 26 ++
 rtl/mdio_arbiter_if.sv | 25 ++
 rtl/mdio_rr_picker.sv | 32 +++
 rtl/mdio_arbiter.sv | 129 ++++++++++++
 tb/tb_mdio_arbiter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mdio_arbiter_pkg.sv
// Shared definitions for the MDIO arbiter: Clause-22 frame fields and FSM encoding.
package mdio_pkg;

  localparam logic [1:0] ST_C22   = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  localparam int F_ST_LSB   = 30;
  localparam int F_OP_LSB   = 28;
  localparam int F_PHY_LSB  = 23;
  localparam int F_REG_LSB  = 18;
  localparam int F_TA_LSB   = 16;
  localparam int F_DATA_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } state_e;

  function automatic logic [1:0] frame_op(input logic [31:0] frame);
    return frame[F_OP_LSB +: 2];
  endfunction

endpackage

// File: rtl/mdio_arbiter_if.sv
// Requester and controller-side signals of the MDIO arbiter; slave = arbiter view.
interface mdio_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    REQ;
  logic [32*N_REQ-1:0] REQ_T_DATA;
  logic [N_REQ-1:0]    GNT;
  logic [N_REQ-1:0]    DONE;
  logic                ERR;
  logic [15:0]         RD_DATA;
  logic                CTL_START;
  logic [31:0]         CTL_T_DATA;
  logic                CTL_DONE;
  logic [15:0]         CTL_RD_DATA;

  modport slave (
    input  REQ, REQ_T_DATA, CTL_DONE, CTL_RD_DATA,
    output GNT, DONE, ERR, RD_DATA, CTL_START, CTL_T_DATA
  );

  modport master (
    output REQ, REQ_T_DATA, CTL_DONE, CTL_RD_DATA,
    input  GNT, DONE, ERR, RD_DATA, CTL_START, CTL_T_DATA
  );
endinterface

// File: rtl/mdio_rr_picker.sv
// Rotating-priority encoder: first set request at or above ptr_i, wrapping modulo N_REQ.
module mdio_rr_picker #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] idx_o
);
  localparam int PW = $clog2(N_REQ);

  always_comb begin
    logic        found;
    int unsigned cand;
    logic [PW-1:0] c;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    c     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = 32'(ptr_i) + k;
      if (cand >= 32'(N_REQ)) cand = cand - 32'(N_REQ);
      c = PW'(cand);
      if (!found && req_i[c]) begin
        found    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = c;
      end
    end
  end
endmodule

// File: rtl/mdio_arbiter.sv
// Shares one MDIO controller between N_REQ requesters with timeout and inter-frame gap.
// Define MDIO_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module mdio_arbiter
  import mdio_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int TIMEOUT    = 1024,
  parameter int IFG_CYCLES = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  mdio_arbiter_if.slave bus
);
  localparam int PW   = $clog2(N_REQ);
  localparam int TMAX = (TIMEOUT > IFG_CYCLES) ? TIMEOUT : IFG_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] IFG_LAST = TW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic              err_q, err_d;
  logic [15:0]       rd_q, rd_d;
  logic [31:0]       frame_q, frame_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     pick_idx;
  logic [N_REQ-1:0]  pick_gnt;
  logic              wait_exit;

  mdio_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req_i (bus.REQ),
    .ptr_i (ptr),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

`ifdef MDIO_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [PW-1:0] rr_q;
  logic [PW-1:0] idx_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rr_q  <= '0;
      idx_q <= '0;
    end else begin
      if (state_q == S_IDLE && |bus.REQ) idx_q <= pick_idx;
      if (wait_exit) rr_q <= (idx_q == PW'(N_REQ - 1)) ? '0 : idx_q + PW'(1);
    end
  end

  assign ptr = rr_q;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    err_d     = 1'b0;
    rd_d      = rd_q;
    frame_d   = frame_q;
    timer_d   = timer_q;
    wait_exit = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|bus.REQ) begin
          gnt_d   = pick_gnt;
          frame_d = bus.REQ_T_DATA[{pick_idx, 5'd0} +: 32];
          state_d = S_START;
        end
      end
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        // Controller completion takes precedence over a coincident timeout.
        if (bus.CTL_DONE || timer_q == TMO_LAST) begin
          wait_exit = 1'b1;
          done_d    = gnt_q;
          err_d     = !bus.CTL_DONE;
          if (bus.CTL_DONE && frame_op(frame_q) == OP_READ) rd_d = bus.CTL_RD_DATA;
          gnt_d     = '0;
          timer_d   = '0;
          state_d   = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        timer_d = timer_q + TW'(1);
        if (timer_q == IFG_LAST) begin
          timer_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rd_q    <= '0;
      frame_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      frame_q <= frame_d;
      timer_q <= timer_d;
    end
  end

  assign bus.GNT        = gnt_q;
  assign bus.DONE       = done_q;
  assign bus.ERR        = err_q;
  assign bus.RD_DATA    = rd_q;
  assign bus.CTL_T_DATA = frame_q;
  assign bus.CTL_START  = (state_q == S_START);
endmodule

// File: tb/tb_mdio_arbiter.sv
// Scoreboard bench for mdio_arbiter: directed transactions, controller model, decoupled monitor.
module tb_mdio_arbiter;
  localparam int N   = 4;
  localparam int T   = 1024;
  localparam int IFG = 4;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  mdio_arbiter_if #(.N_REQ(N)) bus ();

  mdio_arbiter #(.N_REQ(N), .TIMEOUT(T), .IFG_CYCLES(IFG)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  typedef struct {
    logic [N-1:0] gnt;
    logic [31:0]  frame;
    int           delay;
    logic [15:0]  rdata;
    logic         err;
    logic [15:0]  rd;
    int           req_cyc;
    bit           gap_chk;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int last_done_cyc = 0;
  int stray_req = 0;
  int stray_ack = 0;
  logic [31:0] frames [N] = '{32'h5082_ABCD, 32'h6082_0000, 32'h5104_1111, 32'h6186_0000};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Monitor: checks every start against the queue head and pops on DONE
  initial begin
    exp_t e;
    int eff;
    forever begin
      @(negedge CLK);
      if (bus.CTL_START === 1'b1) begin
        if (q.size() == 0) chk("unexpected_start", 32'(bus.CTL_START), 32'd0);
        else begin
          start_cyc = cyc;
          chk("start_gnt", 32'(bus.GNT), 32'(q[0].gnt));
          chk("start_frame", bus.CTL_T_DATA, q[0].frame);
          if (q[0].req_cyc >= 0) chk("start_latency", start_cyc - q[0].req_cyc, 32'd1);
          if (q[0].gap_chk) chk("ifg_gap", start_cyc - last_done_cyc, IFG + 1);
        end
      end
      if (bus.DONE !== '0) begin
        if (q.size() == 0) chk("unexpected_done", 32'(bus.DONE), 32'd0);
        else begin
          e   = q.pop_front();
          eff = (e.delay < 0 || e.delay > T) ? T : e.delay;
          chk("done_mask", 32'(bus.DONE), 32'(e.gnt));
          chk("done_err", 32'(bus.ERR), 32'(e.err));
          chk("rd_data", 32'(bus.RD_DATA), 32'(e.rd));
          chk("done_cycle", cyc, start_cyc + eff + 1);
          chk("gnt_cleared", 32'(bus.GNT), 32'd0);
          last_done_cyc = cyc;
        end
      end
    end
  end

  // Controller model: completes delay cycles after start (negative = never)
  initial begin
    int d;
    bus.CTL_DONE    = 1'b0;
    bus.CTL_RD_DATA = '0;
    forever begin
      @(negedge CLK);
      if (bus.CTL_START === 1'b1 && q.size() != 0) begin
        d = q[0].delay;
        bus.CTL_RD_DATA = q[0].rdata;
        if (d > 0) begin
          repeat (d) @(posedge CLK);
          #1 bus.CTL_DONE = 1'b1;
          @(posedge CLK);
          #1 bus.CTL_DONE = 1'b0;
        end
      end else if (stray_req != stray_ack) begin
        stray_ack = stray_req;
        bus.CTL_RD_DATA = 16'hFFFF;
        @(posedge CLK);
        #1 bus.CTL_DONE = 1'b1;
        @(posedge CLK);
        #1 bus.CTL_DONE = 1'b0;
      end
    end
  end

  task automatic push(input logic [N-1:0] g, input logic [31:0] frame, input int d,
                      input logic [15:0] rdata, input logic err, input logic [15:0] rd,
                      input int req_cyc, input bit gap);
    exp_t e;
    e.gnt = g; e.frame = frame; e.delay = d; e.rdata = rdata;
    e.err = err; e.rd = rd; e.req_cyc = req_cyc; e.gap_chk = gap;
    q.push_back(e);
  endtask

  task automatic wait_qsize(input int n, input int budget);
    int k = 0;
    while (q.size() > n && k < budget) begin
      @(negedge CLK);
      #1;
      k++;
    end
    if (q.size() > n) begin
      checks++;
      failures++;
      $display("FAIL wait_done: queue=%0d expected<=%0d after %0d cycles", q.size(), n, budget);
      q.delete();
      bus.REQ = '0;
    end
  endtask

  task automatic gap_wait();
    repeat (IFG + 3) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("rst_gnt", 32'(bus.GNT), 32'd0);
    chk("rst_done", 32'(bus.DONE), 32'd0);
    chk("rst_err", 32'(bus.ERR), 32'd0);
    chk("rst_start", 32'(bus.CTL_START), 32'd0);
    chk("rst_ctl_data", bus.CTL_T_DATA, 32'd0);
    chk("rst_rd_data", 32'(bus.RD_DATA), 32'd0);
    RESET = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [15:0] rd;
    int i;
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    int i;
    bus.REQ        = '0;
    bus.REQ_T_DATA = {frames[3], frames[2], frames[1], frames[0]};
    RESET          = 1'b1;
    repeat (2) @(posedge CLK);
    do_reset();

    // single write, RD_DATA must stay 0 despite controller data on the bus
    push(4'b0001, frames[0], 64, 16'hDEAD, 1'b0, 16'h0000, cyc, 1'b0);
    bus.REQ = 4'b0001;
    wait_qsize(0, 200);
    bus.REQ = '0;
    gap_wait();

    // single read
    push(4'b0010, frames[1], 5, 16'hAAAA, 1'b0, 16'hAAAA, cyc, 1'b0);
    bus.REQ = 4'b0010;
    wait_qsize(0, 100);
    bus.REQ = '0;
    gap_wait();

    // CTL_DONE while idle is ignored
    stray_req++;
    repeat (5) @(posedge CLK);
    #1;
    chk("stray_rd", 32'(bus.RD_DATA), 32'h0000_AAAA);

    // contention from a fresh pointer: order 0,1,2,3,0,1,2,3
    do_reset();
    rd = 16'h0000;
    for (int k = 0; k < 8; k++) begin
      i = k % 4;
      if (i % 2 == 1) rd = 16'h1000 + 16'(k);
      push(4'(1 << i), frames[i], 3 + i, 16'h1000 + 16'(k), 1'b0, rd, -1, k > 0);
    end
    bus.REQ = 4'b1111;
    wait_qsize(0, 400);
    bus.REQ = '0;
    gap_wait();

    // timeout: controller silent
    push(4'b0100, frames[2], -1, 16'h5555, 1'b1, 16'h1007, cyc, 1'b0);
    bus.REQ = 4'b0100;
    wait_qsize(0, T + 50);
    bus.REQ = '0;
    gap_wait();

    // next request served normally
    push(4'b0001, frames[0], 3, 16'h2222, 1'b0, 16'h1007, cyc, 1'b0);
    bus.REQ = 4'b0001;
    wait_qsize(0, 100);
    bus.REQ = '0;
    gap_wait();

    // CTL_DONE in the timeout cycle wins
    push(4'b0010, frames[1], T, 16'hBEEF, 1'b0, 16'hBEEF, cyc, 1'b0);
    bus.REQ = 4'b0010;
    wait_qsize(0, T + 50);
    bus.REQ = '0;
    gap_wait();

    // reset during WAIT aborts with no DONE
    push(4'b1000, frames[3], -1, 16'h3333, 1'b0, 16'h0000, cyc, 1'b0);
    bus.REQ = 4'b1000;
    repeat (10) @(posedge CLK);
    #1;
    bus.REQ = '0;
    void'(q.pop_front());
    do_reset();
    repeat (5) @(posedge CLK);
    #1;

    // pointer restarts at 0: requester 1 before 3
    push(4'b0010, frames[1], 2, 16'h0F0F, 1'b0, 16'h0F0F, cyc, 1'b0);
    push(4'b1000, frames[3], 2, 16'h7777, 1'b0, 16'h7777, -1, 1'b1);
    bus.REQ = 4'b1010;
    wait_qsize(1, 100);
    bus.REQ = 4'b1000;
    wait_qsize(0, 100);
    bus.REQ = '0;
    gap_wait();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
